// File: rtl/reg_file_sb.sv
// Integer register file with an issue scoreboard for RAW/WAW hazards.
// x0 reads zero; writeback data is bypassed to both read ports.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      read_addr_rs1,
  input  logic [4:0]      read_addr_rs2,
  output logic [XLEN-1:0] data_rs1,
  output logic [XLEN-1:0] data_rs2,
  input  logic            we,
  input  logic [4:0]      write_addr_rd,
  input  logic [XLEN-1:0] write_data_rd,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_has_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  output logic [5:0]      pending_count
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nx;
  logic [5:0]      cnt_nx;
  logic            wb_ok;
  logic            hit1;
  logic            hit2;
  logic            hitd;
  logic            rd_busy;
  logic            accept;

  assign wb_ok = we && (write_addr_rd != 5'd0);
  assign hit1  = wb_ok && (write_addr_rd == read_addr_rs1);
  assign hit2  = wb_ok && (write_addr_rd == read_addr_rs2);
  assign hitd  = wb_ok && (write_addr_rd == issue_rd);

  // pend[0] is never set, so x0 can never look busy
  assign rs1_busy = pend[read_addr_rs1] && !hit1;
  assign rs2_busy = pend[read_addr_rs2] && !hit2;
  assign rd_busy  = issue_has_rd && pend[issue_rd] && !hitd;
  assign stall    = issue_valid && (rs1_busy || rs2_busy || rd_busy);
  assign accept   = issue_valid && !stall;

  always_comb begin
    data_rs1 = '0;
    if (read_addr_rs1 == 5'd0) data_rs1 = '0;
    else if (hit1)             data_rs1 = write_data_rd;
    else                       data_rs1 = regs[read_addr_rs1];
  end

  always_comb begin
    data_rs2 = '0;
    if (read_addr_rs2 == 5'd0) data_rs2 = '0;
    else if (hit2)             data_rs2 = write_data_rd;
    else                       data_rs2 = regs[read_addr_rs2];
  end

  // clear first, then set, so a re-issue on a retiring rd stays pending
  always_comb begin
    pend_nx = pend;
    if (wb_ok)
      pend_nx[write_addr_rd] = 1'b0;
    if (accept && issue_has_rd && (issue_rd != 5'd0))
      pend_nx[issue_rd] = 1'b1;
  end

  always_comb begin
    cnt_nx = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nx = cnt_nx + 6'(pend_nx[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend          <= '0;
      pending_count <= '0;
    end else begin
      pend          <= pend_nx;
      pending_count <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_ok) begin
      regs[write_addr_rd] <= write_data_rd;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: storage, bypass, scoreboard, reset.
// Inputs change 1ns after posedge; outputs sampled before the next edge.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_addr_rs1;
  logic [4:0]  read_addr_rs2;
  logic [31:0] data_rs1;
  logic [31:0] data_rs2;
  logic        we;
  logic [4:0]  write_addr_rd;
  logic [31:0] write_data_rd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_has_rd;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall;
  logic [5:0]  pending_count;

  int total;
  int passed;

  reg_file_sb #(.XLEN(32), .NREG(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .read_addr_rs1(read_addr_rs1),
    .read_addr_rs2(read_addr_rs2),
    .data_rs1(data_rs1),
    .data_rs2(data_rs2),
    .we(we),
    .write_addr_rd(write_addr_rd),
    .write_data_rd(write_data_rd),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_has_rd(issue_has_rd),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .stall(stall),
    .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    write_addr_rd = '0;
    write_data_rd = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_has_rd = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    read_addr_rs1 = 5'd0;
    read_addr_rs2 = 5'd5;
    rst_n = 1'b0;
    #12;
    total++;
    if (data_rs1 !== 32'h0)
      $display("FAIL reset_rs1 got %h want %h", data_rs1, 32'h0);
    else passed++;
    total++;
    if (data_rs2 !== 32'h0)
      $display("FAIL reset_rs2 got %h want %h", data_rs2, 32'h0);
    else passed++;
    total++;
    if ({stall, rs1_busy, rs2_busy} !== 3'b000)
      $display("FAIL reset_busy got %b want 000",
               {stall, rs1_busy, rs2_busy});
    else passed++;
    total++;
    if (pending_count !== 6'd0)
      $display("FAIL reset_count got %0d want 0", pending_count);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    we = 1'b1;
    write_addr_rd = 5'd1;
    write_data_rd = 32'd7;
    step();
    idle();
    read_addr_rs2 = 5'd1;
    #1;
    total++;
    if (data_rs2 !== 32'h7)
      $display("FAIL write_x1 got %h want %h", data_rs2, 32'h7);
    else passed++;
    we = 1'b1;
    write_addr_rd = 5'd0;
    write_data_rd = 32'hDEAD;
    read_addr_rs1 = 5'd0;
    #1;
    total++;
    if (data_rs1 !== 32'h0)
      $display("FAIL x0_bypass got %h want %h", data_rs1, 32'h0);
    else passed++;
    step();
    idle();
    #1;
    total++;
    if (data_rs1 !== 32'h0)
      $display("FAIL x0_write got %h want %h", data_rs1, 32'h0);
    else passed++;
  endtask

  task automatic test_bypass();
    we = 1'b1;
    write_addr_rd = 5'd3;
    write_data_rd = 32'h55;
    read_addr_rs1 = 5'd3;
    #1;
    total++;
    if (data_rs1 !== 32'h55)
      $display("FAIL bypass got %h want %h", data_rs1, 32'h55);
    else passed++;
    step();
    idle();
    #1;
    total++;
    if (data_rs1 !== 32'h55)
      $display("FAIL stored_x3 got %h want %h", data_rs1, 32'h55);
    else passed++;
  endtask

  task automatic test_raw();
    read_addr_rs1 = 5'd0;
    read_addr_rs2 = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd4;
    issue_has_rd = 1'b1;
    step();
    total++;
    if (pending_count !== 6'd1)
      $display("FAIL raw_count1 got %0d want 1", pending_count);
    else passed++;
    issue_rd = 5'd8;
    read_addr_rs1 = 5'd4;
    #1;
    total++;
    if ({rs1_busy, stall} !== 2'b11)
      $display("FAIL raw_stall got %b want 11", {rs1_busy, stall});
    else passed++;
    step();
    total++;
    if (pending_count !== 6'd1)
      $display("FAIL raw_hold got %0d want 1", pending_count);
    else passed++;
    // writeback of x4 lands in the issue cycle and releases it
    we = 1'b1;
    write_addr_rd = 5'd4;
    write_data_rd = 32'h1234;
    #1;
    total++;
    if ({rs1_busy, stall} !== 2'b00)
      $display("FAIL raw_release got %b want 00", {rs1_busy, stall});
    else passed++;
    total++;
    if (data_rs1 !== 32'h1234)
      $display("FAIL raw_fwd got %h want %h", data_rs1, 32'h1234);
    else passed++;
    step();
    idle();
    read_addr_rs2 = 5'd8;
    #1;
    total++;
    if ({pending_count, rs1_busy, rs2_busy} !== {6'd1, 2'b01})
      $display("FAIL raw_swap got %0d/%b want 1/01",
               pending_count, {rs1_busy, rs2_busy});
    else passed++;
    we = 1'b1;
    write_addr_rd = 5'd8;
    write_data_rd = 32'h88;
    step();
    idle();
    total++;
    if (pending_count !== 6'd0)
      $display("FAIL raw_drain got %0d want 0", pending_count);
    else passed++;
  endtask

  task automatic test_waw();
    read_addr_rs1 = 5'd0;
    read_addr_rs2 = 5'd0;
    issue_valid = 1'b1;
    issue_rd = 5'd6;
    issue_has_rd = 1'b1;
    step();
    #1;
    total++;
    if (stall !== 1'b1)
      $display("FAIL waw_stall got %b want 1", stall);
    else passed++;
    we = 1'b1;
    write_addr_rd = 5'd6;
    write_data_rd = 32'h66;
    #1;
    total++;
    if (stall !== 1'b0)
      $display("FAIL waw_release got %b want 0", stall);
    else passed++;
    step();
    we = 1'b0;
    #1;
    total++;
    if ({pending_count, stall} !== {6'd1, 1'b1})
      $display("FAIL waw_reset_bit got %0d/%b want 1/1",
               pending_count, stall);
    else passed++;
    idle();
    we = 1'b1;
    write_addr_rd = 5'd6;
    step();
    idle();
    // an x0 destination never marks anything pending
    issue_valid = 1'b1;
    issue_rd = 5'd0;
    issue_has_rd = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0)
      $display("FAIL x0_issue_stall got %b want 0", stall);
    else passed++;
    step();
    idle();
    total++;
    if (pending_count !== 6'd0)
      $display("FAIL x0_issue_count got %0d want 0", pending_count);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [4:0] rds [3];
    rds[0] = 5'd2;
    rds[1] = 5'd9;
    rds[2] = 5'd12;
    we = 1'b1;
    write_addr_rd = 5'd3;
    write_data_rd = 32'hCAFE;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_rd = rds[i];
      issue_has_rd = 1'b1;
      step();
    end
    idle();
    read_addr_rs1 = 5'd9;
    read_addr_rs2 = 5'd3;
    #1;
    total++;
    if ({pending_count, rs1_busy} !== {6'd3, 1'b1})
      $display("FAIL pre_reset got %0d/%b want 3/1",
               pending_count, rs1_busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pending_count, rs1_busy, rs2_busy} !== {6'd0, 2'b00})
      $display("FAIL mid_reset_sb got %0d/%b want 0/00",
               pending_count, {rs1_busy, rs2_busy});
    else passed++;
    total++;
    if (data_rs2 !== 32'h0)
      $display("FAIL mid_reset_reg got %h want %h", data_rs2, 32'h0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1;
    write_addr_rd = 5'd5;
    write_data_rd = 32'hA5;
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    issue_has_rd = 1'b1;
    step();
    idle();
    read_addr_rs1 = 5'd5;
    read_addr_rs2 = 5'd9;
    #1;
    total++;
    if ({data_rs1, pending_count, rs2_busy} !==
        {32'hA5, 6'd1, 1'b1})
      $display("FAIL post_reset got %h/%0d/%b want a5/1/1",
               data_rs1, pending_count, rs2_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_raw();
    test_waw();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Integer register file with an integrated issue scoreboard. It serves the decode-stage read and writeback-stage write traffic of the core's register-file interface, and reports read-after-write and write-after-write hazards to the issue logic. x0 is hardwired to zero. Same-cycle writeback data is forwarded to both read ports.

Parameters:
XLEN, 32, data width of each register.
NREG, 32, number of architectural registers. Address width is 5 and is fixed for NREG=32.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
read_addr_rs1  input  5  source register 1 address.
read_addr_rs2  input  5  source register 2 address.
data_rs1  output  XLEN  rs1 read data, combinational.
data_rs2  output  XLEN  rs2 read data, combinational.
we  input  1  writeback enable.
write_addr_rd  input  5  writeback destination.
write_data_rd  input  XLEN  writeback data.
issue_valid  input  1  issue stage requests to dispatch an instruction.
issue_rd  input  5  destination of the issuing instruction.
issue_has_rd  input  1  issuing instruction writes a register.
rs1_busy  output  1  rs1 has a pending write not yet satisfied.
rs2_busy  output  1  rs2 has a pending write not yet satisfied.
stall  output  1  issue blocked this cycle.
pending_count  output  6  registered count of pending bits set.

Behaviour:
- Async reset (rst_n low): all registers 0, all pending bits 0, pending_count 0, regardless of clk. With we=0 the read ports then return 0, and busy and stall outputs are 0.
- Storage: regs[1..31] are flops. x0 is never written and always reads 0. A write to x0 is ignored and clears nothing.
- Write: on posedge, if we and write_addr_rd != 0, regs[write_addr_rd] <= write_data_rd. The value is visible on a read port 1 cycle later without bypass.
- Read (combinational):
  - data_rsN = 0 if addr == 0.
  - Else, write_data_rd if we && write_addr_rd == addr (same-cycle bypass).
  - Else regs[addr].
- Pending bits pend[1..31]:
  - wb_hit(a) = we && write_addr_rd == a && a != 0.
  - rsN_busy = pend[read_addr_rsN] && !wb_hit(read_addr_rsN). This is 0 for x0.
  - rd_busy = issue_has_rd && pend[issue_rd] && !wb_hit(issue_rd).
  - stall = issue_valid && (rs1_busy || rs2_busy || rd_busy).
  - accept = issue_valid && !stall.
- Pending update on posedge:
  - If wb_hit(write_addr_rd), clear pend[write_addr_rd].
  - Then, if accept && issue_has_rd && issue_rd != 0, set pend[issue_rd]. Set wins on the same register.
  - A write to a non-pending register is legal, updates data, and leaves the bits unchanged.
- pending_count tracks the population of pend at all times:
  - +1 when a bit goes 0->1.
  - -1 when a bit goes 1->0.
  - Net 0 when both occur on different registers, or when the same register is cleared and re-set.
  - Never wraps; max 31.
- Reset asserted mid-operation: state clears immediately. The first post-reset edge behaves as from cold reset.
- Busy, stall and read data are purely combinational from current state and inputs. There are no added cycles of latency.

Test Plan:
1. Reset, then read rs1=0 and rs2=5 -> data_rs1=0, data_rs2=0, stall=0, pending_count=0.
2. we=1, rd=1, data=7; after posedge+1ns read rs2=1 -> data_rs2=0x00000007. Repeat with rd=0, data=0xDEAD -> read x0 = 0.
3. Same cycle: we=1, rd=3, data=0x55, read rs1=3 before the edge -> data_rs1=0x55 (bypass). After the edge, regs[3]=0x55.
4. Issue rd=4 accepted -> pending_count=1. Next cycle issue with rs1=4 -> rs1_busy=1, stall=1, pending_count stays 1. Then wb rd=4 in the same cycle as the issue -> rs1_busy=0, stall=0, data_rs1 = wb data.
5. WAW: pend[6] set; issue rd=6 -> stall=1. Issue rd=6 coincident with wb rd=6 -> accepted, pend[6] remains 1, pending_count unchanged.
6. Set pend[2], pend[9], pend[12] (count=3); assert rst_n low between edges -> count=0, regs 0, busy outputs 0 immediately.
